reg_file_param: RTL

Parametrised register file with one synchronous write port and two asynchronous read ports, generalising the 2-to-4 write decoder and 4-to-1 read mux pair to any power-of-two depth and any data width. It sits between instruction decode and the ALU in the datapath. It adds three behaviours the fixed four-register arrangement lacks: a second read port, optional write-to-read bypass, and optional hardwired-zero register 0. It also keeps a per-register "written since reset" status vector for the hazard and debug logic.

---
 rtl/reg_file_param.sv | 78 +++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: one synchronous write port, two combinational read
// ports, optional write-to-read bypass, optional hardwired-zero register 0.
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_no,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_no1,
    input  logic [$clog2(DEPTH)-1:0]   rd_no2,
    output logic [WIDTH-1:0]           rd_data1,
    output logic [WIDTH-1:0]           rd_data2,
    output logic [DEPTH-1:0]           written
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_written;
    logic [DEPTH-1:0] w_wr_dec;
    logic             w_fwd_ok;

    // One-hot write strobe; register 0 is masked out when it is hardwired to zero.
    always_comb begin
        w_wr_dec = '0;
        if (wr_en) begin
            w_wr_dec[wr_no] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_wr_dec[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_written <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_dec[i]) begin
                    r_regs[i]    <= wr_data;
                    r_written[i] <= 1'b1;
                end
            end
        end
    end

    // Forwarding is only legal when the write will actually land on this edge.
    assign w_fwd_ok = (BYPASS != 0) && reset && wr_en;

    always_comb begin
        rd_data1 = r_regs[rd_no1];
        if ((ZERO_REG != 0) && (rd_no1 == AW'(0))) begin
            rd_data1 = '0;
        end else if (w_fwd_ok && (wr_no == rd_no1)) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = r_regs[rd_no2];
        if ((ZERO_REG != 0) && (rd_no2 == AW'(0))) begin
            rd_data2 = '0;
        end else if (w_fwd_ok && (wr_no == rd_no2)) begin
            rd_data2 = wr_data;
        end
    end

    assign written = r_written;

endmodule
